div_sequencer: RTL and testbench

- Multi-cycle controller plus datapath for the RV32M divide instructions DIV, DIVU, REM and REMU.
- Sequences a restoring radix-2 shift/subtract datapath built from enable-gated registers.
- Sits beside the EX-stage ALU. Accepts one operation at a time via a valid/ready handshake and returns the result via valid/ready.
- The hazard unit stalls the pipeline while busy is high.

---
 rtl/div_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_div_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) using a restoring radix-2 datapath.
// One operation in flight at a time; request and response use valid/ready handshakes.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's complement negation, ~x + 1.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x);
    f_neg = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_result;
  logic               r_rem_sel;
  logic               r_dd_neg;
  logic               r_dv_neg;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_in_ready;

  logic               w_signed_in;
  logic               w_dd_neg;
  logic               w_dv_neg;
  logic [WIDTH-1:0]   w_dd_mag;
  logic [WIDTH-1:0]   w_dv_mag;
  logic               w_div_zero;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_spec_quo;
  logic [WIDTH-1:0]   w_spec_rem;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_iter_quo;
  logic [WIDTH-1:0]   w_iter_rem;
  logic [WIDTH-1:0]   w_fix_quo;
  logic [WIDTH-1:0]   w_fix_rem;
  logic               w_ld_spec;
  logic               w_ld_norm;
  logic               w_iter;
  logic               w_fix;

  // Operand decode at accept time: signedness, magnitudes and special cases.
  assign w_signed_in = ~op[0];
  assign w_dd_neg    = w_signed_in & dividend[WIDTH-1];
  assign w_dv_neg    = w_signed_in & divisor[WIDTH-1];
  assign w_dd_mag    = w_dd_neg ? f_neg(dividend) : dividend;
  assign w_dv_mag    = w_dv_neg ? f_neg(divisor) : divisor;
  assign w_div_zero  = (divisor == ZERO);
  assign w_ovf       = w_signed_in & (dividend == MINNEG) & (divisor == ONES);
  assign w_spec_quo  = w_div_zero ? ONES : dividend;
  assign w_spec_rem  = w_div_zero ? dividend : ZERO;

  // The shifted partial remainder is below 2*divisor, so bit WIDTH of the trial is its sign.
  assign w_shift     = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_shift - {1'b0, r_div};
  assign w_ge        = ~w_trial[WIDTH];
  assign w_iter_quo  = {r_quo[WIDTH-2:0], w_ge};
  assign w_iter_rem  = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

  assign w_fix_quo   = (r_dd_neg ^ r_dv_neg) ? f_neg(r_quo) : r_quo;
  assign w_fix_rem   = r_dd_neg ? f_neg(r_rem) : r_rem;

  // Next-state and datapath enable decode.
  always_comb begin
    w_next_state = r_state;
    w_ld_spec    = 1'b0;
    w_ld_norm    = 1'b0;
    w_iter       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          if (w_div_zero || w_ovf) begin
            w_ld_spec    = 1'b1;
            w_next_state = S_DONE;
          end else begin
            w_ld_norm    = 1'b1;
            w_next_state = S_BUSY;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_BUSY: begin
        if (flush) begin
          w_next_state = S_IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = S_FIX;
          end else begin
            w_next_state = S_BUSY;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          w_next_state = S_IDLE;
        end else begin
          w_fix        = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      r_out_valid <= (w_next_state == S_DONE);
      r_busy      <= (w_next_state != S_IDLE);
      r_in_ready  <= (w_next_state == S_IDLE);
    end
  end

  // Enable-gated datapath registers; nothing here changes while waiting in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_quo     <= ZERO;
      r_rem     <= ZERO;
      r_div     <= ZERO;
      r_result  <= ZERO;
      r_rem_sel <= 1'b0;
      r_dd_neg  <= 1'b0;
      r_dv_neg  <= 1'b0;
    end else if (w_ld_spec) begin
      r_quo     <= w_spec_quo;
      r_rem     <= w_spec_rem;
      r_result  <= op[1] ? w_spec_rem : w_spec_quo;
      r_rem_sel <= op[1];
      r_dd_neg  <= w_dd_neg;
      r_dv_neg  <= w_dv_neg;
      r_cnt     <= {CNT_W{1'b0}};
    end else if (w_ld_norm) begin
      r_quo     <= w_dd_mag;
      r_rem     <= ZERO;
      r_div     <= w_dv_mag;
      r_cnt     <= CNT_W'(WIDTH);
      r_rem_sel <= op[1];
      r_dd_neg  <= w_dd_neg;
      r_dv_neg  <= w_dv_neg;
    end else if (w_iter) begin
      r_quo     <= w_iter_quo;
      r_rem     <= w_iter_rem;
      r_cnt     <= r_cnt - CNT_W'(1);
    end else if (w_fix) begin
      r_quo     <= w_fix_quo;
      r_rem     <= w_fix_rem;
      r_result  <= r_rem_sel ? w_fix_rem : w_fix_quo;
    end
  end

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign result    = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed, table-driven bench for div_sequencer plus hand-written backpressure,
// flush and reset-abort sequences.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dividend(dividend), .divisor(divisor), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op at a negedge; the following posedge is the accept edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; dividend = a; divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the first negedge after the accept edge.
  task automatic wait_valid(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit bok;
    start_op(o, a, b);
    wait_valid(lat, bok);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, result, exp);
    chk({name, "_busy"}, {31'd0, bok & busy}, 32'd1);
    release_result();
  endtask

  // Abort an op in BUSY after n cycles, using flush or reset.
  task automatic abort_run(input string name, input int n, input bit use_rst);
    bit seen = 1'b0;
    start_op(2'b00, 32'd100, 32'd7);
    repeat (n - 1) @(negedge clk);
    chk({name, "_busy_mid"}, {31'd0, busy}, 32'd1);
    if (use_rst) rst_n = 1'b0; else flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0;
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({name, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    chk({name, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
    if (use_rst) chk({name, "_result_cleared"}, result, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) seen = 1'b1;
      @(negedge clk);
    end
    chk({name, "_stays_idle"}, {31'd0, seen}, 32'd0);
    run_vec({name, "_divu_9_3"}, 2'b01, 32'd9, 32'd3, 32'd3, 34);
  endtask

  initial begin
    int lat;
    bit bok;
    bit stable;

    vecs[0]  = '{2'b00, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{2'b10, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34};
    vecs[4]  = '{2'b01, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   34};
    vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1};
    vecs[7]  = '{2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1};
    vecs[8]  = '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
    vecs[9]  = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[10] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[11] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34};
    vecs[12] = '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34};
    vecs[13] = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          34};
    vecs[14] = '{2'b11, 32'hFFFFFFFF,   32'd16,         32'd15,         34};
    vecs[15] = '{2'b00, 32'h80000000,   32'd1,          32'h80000000,   34};

    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; dividend = 32'd0; divisor = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush in IDLE blocks a same-cycle accept.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    chk("idle_flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Backpressure: result held, new requests ignored while DONE.
    start_op(2'b00, 32'd100, 32'd7);
    wait_valid(lat, bok);
    chk("bp_latency", 32'(lat), 32'd34);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      if (result !== 32'd14 || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_stable", {31'd0, stable}, 32'd1);
    chk("bp_result", result, 32'd14);
    release_result();
    run_vec("bp_next_divu", 2'b01, 32'd9, 32'd3, 32'd3, 34);

    // Flush and out_ready together in DONE discard the result.
    start_op(2'b01, 32'd5, 32'd0);
    wait_valid(lat, bok);
    chk("done_flush_latency", 32'(lat), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("done_flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("done_flush_busy", {31'd0, busy}, 32'd0);

    abort_run("flush10", 10, 1'b0);
    abort_run("reset20", 20, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
